// File: rtl/tile_pkg.sv
// Shared definitions for the tile map scheduler.
// Contents: FSM state encodings and the typed state enum, the transparent tile id used by the
// optional TILE_SKIP_EN build, and the default screen geometry that sizes the default map.
package tile_pkg;

  // State encodings.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ADVANCE   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  typedef enum logic [2:0] {
    StIdle     = S_IDLE,
    StFetch    = S_FETCH,
    StWaitData = S_WAIT_DATA,
    StIssue    = S_ISSUE,
    StWaitDone = S_WAIT_DONE,
    StAdvance  = S_ADVANCE,
    StDone     = S_DONE
  } state_e;

  // Map entry that is not drawn when TILE_SKIP_EN is defined.
  localparam logic [7:0] SKIP_TILE_ID = 8'hFF;

  // Default screen geometry; the default map covers it exactly with 8x8 tiles.
  localparam int unsigned SCREEN_W       = 160;
  localparam int unsigned SCREEN_H       = 120;
  localparam int unsigned DEFAULT_TILE_W = 8;
  localparam int unsigned DEFAULT_TILE_H = 8;

endpackage

// File: rtl/tile_cursor.sv
// Map walk cursor: column/row counters, linear map index and running pixel origin.
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   clear_i          return to the first tile (col=row=idx=x=y=0)
//   advance_i        step to the next tile in row-major order (ignored on the last tile)
//   idx_o            linear index row*MAP_COLS+col
//   x_o, y_o         pixel origin of the current tile (accumulated, no multipliers)
//   last_tile_o      current tile is the final one of the map
//   col_wrap_o       current tile is the last one of its row
module tile_cursor #(
  parameter int unsigned MAP_COLS = 20,
  parameter int unsigned MAP_ROWS = 15,
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned TILE_H   = 8,
  parameter int unsigned MAP_AW   = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [MAP_AW-1:0] idx_o,
  output logic [7:0]        x_o,
  output logic [7:0]        y_o,
  output logic              last_tile_o,
  output logic              col_wrap_o
);

  // Column/row fit in 8 bits because MAP_COLS*TILE_W and MAP_ROWS*TILE_H are <= 256.
  localparam logic [7:0] ColLast = 8'(MAP_COLS - 1);
  localparam logic [7:0] RowLast = 8'(MAP_ROWS - 1);

  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [MAP_AW-1:0] idx_q, idx_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;

  assign col_wrap_o  = (col_q == ColLast);
  assign last_tile_o = col_wrap_o && (row_q == RowLast);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (advance_i && !last_tile_o) begin
      idx_d = idx_q + MAP_AW'(1);
      if (col_wrap_o) begin
        col_d = '0;
        x_d   = '0;
        row_d = row_q + 8'd1;
        y_d   = y_q + 8'(TILE_H);
      end else begin
        col_d = col_q + 8'd1;
        x_d   = x_q + 8'(TILE_W);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign idx_o = idx_q;
  assign x_o   = x_q;
  assign y_o   = y_q;

endmodule

// File: rtl/tile_map_scheduler.sv
// Tile map scheduler: on start, walks a MAP_COLS x MAP_ROWS map in synchronous RAM (row-major)
// and issues one draw/active handshake per entry to the tile drawer, then pulses done.
// Optional build macro: TILE_SKIP_EN -- entries equal to SKIP_TILE_ID are skipped (no draw).
// Ports:
//   clk, resetn      clock and asynchronous active-low reset
//   start            one-cycle request to draw the whole map (ignored while busy)
//   map_rd_addr      map RAM read address (linear index)
//   map_rd_data      map RAM data, valid one cycle after the address
//   tile_address     tile base address to the drawer
//   x_pos, y_pos     tile pixel origin to the drawer
//   draw             draw request; held until drawer_active acknowledges
//   drawer_active    drawer busy flag
//   busy             map walk in progress
//   done             one-cycle pulse after the last tile completes
module tile_map_scheduler
  import tile_pkg::*;
#(
  parameter int unsigned MAP_COLS = SCREEN_W / DEFAULT_TILE_W,
  parameter int unsigned MAP_ROWS = SCREEN_H / DEFAULT_TILE_H,
  parameter int unsigned TILE_W   = DEFAULT_TILE_W,
  parameter int unsigned TILE_H   = DEFAULT_TILE_H,
  parameter int unsigned MAP_AW   = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [MAP_AW-1:0] map_rd_addr,
  input  logic [7:0]        map_rd_data,
  output logic [7:0]        tile_address,
  output logic [7:0]        x_pos,
  output logic [7:0]        y_pos,
  output logic              draw,
  input  logic              drawer_active,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic [7:0] tile_q, tile_d;
  logic [7:0] xpos_q, xpos_d;
  logic [7:0] ypos_q, ypos_d;

  logic              cur_clear;
  logic              cur_advance;
  logic [MAP_AW-1:0] cur_idx;
  logic [7:0]        cur_x;
  logic [7:0]        cur_y;
  logic              last_tile;
  logic              unused_col_wrap;

  tile_cursor #(
    .MAP_COLS (MAP_COLS),
    .MAP_ROWS (MAP_ROWS),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H),
    .MAP_AW   (MAP_AW)
  ) u_cursor (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .clear_i     (cur_clear),
    .advance_i   (cur_advance),
    .idx_o       (cur_idx),
    .x_o         (cur_x),
    .y_o         (cur_y),
    .last_tile_o (last_tile),
    .col_wrap_o  (unused_col_wrap)
  );

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    cur_clear   = 1'b0;
    cur_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_clear = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        // Do not start a tile while the drawer still reports busy from earlier work.
        if (!drawer_active) begin
          state_d = StWaitData;
        end
      end
      StWaitData: begin
`ifdef TILE_SKIP_EN
        if (map_rd_data == SKIP_TILE_ID) begin
          state_d = StAdvance;
        end else begin
          tile_d  = map_rd_data;
          xpos_d  = cur_x;
          ypos_d  = cur_y;
          state_d = StIssue;
        end
`else
        tile_d  = map_rd_data;
        xpos_d  = cur_x;
        ypos_d  = cur_y;
        state_d = StIssue;
`endif
      end
      StIssue: begin
        if (drawer_active) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!drawer_active) begin
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        if (last_tile) begin
          state_d = StDone;
        end else begin
          cur_advance = 1'b1;
          state_d     = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      tile_q  <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
    end
  end

  // Handshake outputs decode straight from the state register so reset clears them at once.
  assign draw         = (state_q == StIssue);
  assign done         = (state_q == StDone);
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign map_rd_addr  = cur_idx;
  assign tile_address = tile_q;
  assign x_pos        = xpos_q;
  assign y_pos        = ypos_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed testbench for tile_map_scheduler: a 2x2 instance and a default 20x15 instance,
// each with a synchronous map RAM model and a simple drawer model.
module tb_tile_map_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 2x2 instance ----------------
  logic       rst_s, start_s, draw_s, busy_s, done_s, act_s, force_s;
  logic [1:0] addr_s;
  logic [7:0] rd_s, tile_s, x_s, y_s;
  logic [7:0] mem_s [4];
  int         cnt_s;
  wire        drv_act_s = act_s | force_s;

  tile_map_scheduler #(
    .MAP_COLS (2),
    .MAP_ROWS (2),
    .TILE_W   (8),
    .TILE_H   (8),
    .MAP_AW   (2)
  ) u_dut_small (
    .clk           (clk),
    .resetn        (rst_s),
    .start         (start_s),
    .map_rd_addr   (addr_s),
    .map_rd_data   (rd_s),
    .tile_address  (tile_s),
    .x_pos         (x_s),
    .y_pos         (y_s),
    .draw          (draw_s),
    .drawer_active (drv_act_s),
    .busy          (busy_s),
    .done          (done_s)
  );

  always @(posedge clk) rd_s <= mem_s[addr_s];

  // Drawer model: acknowledges a draw on the next edge and stays active for 10 cycles.
  initial begin act_s = 1'b0; cnt_s = 0; end
  always @(posedge clk) begin
    if (force_s) begin
      act_s <= 1'b0;
      cnt_s <= 0;
    end else if (act_s) begin
      cnt_s <= cnt_s - 1;
      if (cnt_s == 1) act_s <= 1'b0;
    end else if (draw_s) begin
      act_s <= 1'b1;
      cnt_s <= 10;
    end
  end

  logic [23:0] q_s[$];
  int          done_cnt_s = 0;
  logic        pd_s = 1'b0;
  always @(negedge clk) begin
    if (draw_s && !pd_s) q_s.push_back({tile_s, x_s, y_s});
    pd_s = draw_s;
    if (done_s) done_cnt_s++;
  end

  // ---------------- default 20x15 instance ----------------
  logic       rst_b, start_b, draw_b, busy_b, done_b, act_b;
  logic [8:0] addr_b, last_addr_b;
  logic [7:0] rd_b, tile_b, x_b, y_b;
  logic [7:0] mem_b [512];
  int         cnt_b;

  tile_map_scheduler u_dut_big (
    .clk           (clk),
    .resetn        (rst_b),
    .start         (start_b),
    .map_rd_addr   (addr_b),
    .map_rd_data   (rd_b),
    .tile_address  (tile_b),
    .x_pos         (x_b),
    .y_pos         (y_b),
    .draw          (draw_b),
    .drawer_active (act_b),
    .busy          (busy_b),
    .done          (done_b)
  );

  always @(posedge clk) rd_b <= mem_b[addr_b];

  initial begin act_b = 1'b0; cnt_b = 0; end
  always @(posedge clk) begin
    if (act_b) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) act_b <= 1'b0;
    end else if (draw_b) begin
      act_b <= 1'b1;
      cnt_b <= 2;
    end
  end

  logic [23:0] q_b[$];
  int          done_cnt_b = 0;
  logic        pd_b = 1'b0;
  always @(negedge clk) begin
    if (draw_b && !pd_b) begin
      q_b.push_back({tile_b, x_b, y_b});
      last_addr_b = addr_b;
    end
    pd_b = draw_b;
    if (done_b) done_cnt_b++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) at negedges for the done pulse of the selected instance.
  task automatic wait_done(input bit big, input int budget, input string tag);
    int n = 0;
    while (!(big ? done_b : done_s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < budget), 32'd1);
  endtask

  logic [23:0] exp4 [4];
  int          n0, d0, n, exp_n;
  bit          bad;

  initial begin
    exp4[0] = 24'h030000;
    exp4[1] = 24'h070800;
    exp4[2] = 24'h0B0008;
    exp4[3] = 24'h0F0808;
    mem_s[0] = 8'h03; mem_s[1] = 8'h07; mem_s[2] = 8'h0B; mem_s[3] = 8'h0F;
    for (int i = 0; i < 512; i++) mem_b[i] = 8'(i);
    rst_s = 1'b0; rst_b = 1'b0; start_s = 1'b0; start_b = 1'b0; force_s = 1'b0;

    // Reset state
    #2;
    check("reset_small_outs", {8'h0, draw_s, busy_s, done_s, addr_s, tile_s, x_s, y_s}, 32'd0);
    check("reset_big_outs", {draw_b, busy_b, done_b, addr_b, tile_b, x_b}, 32'd0);
    check("reset_big_y", {24'h0, y_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_s = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Latency and 2x2 walk
    n0 = q_s.size(); d0 = done_cnt_s;
    start_s = 1'b1;
    @(negedge clk);                       // cycle 1
    start_s = 1'b0;
    check("lat_c1_addr", addr_s, 0);
    check("lat_c1_busy", busy_s, 1);
    @(negedge clk);                       // cycle 2
    check("lat_c2_draw", draw_s, 0);
    @(negedge clk);                       // cycle 3
    check("lat_c3_draw", draw_s, 1);
    check("lat_c3_tile", tile_s, 8'h03);
    wait_done(1'b0, 300, "map2x2");
    @(negedge clk);
    check("map2x2_busy_after", busy_s, 0);
    check("map2x2_draw_count", q_s.size() - n0, 4);
    for (int i = 0; i < 4; i++)
      if (n0 + i < q_s.size()) check($sformatf("map2x2_draw%0d", i), q_s[n0+i], exp4[i]);
    check("map2x2_done_pulses", done_cnt_s - d0, 1);

    // Reset while draw is high
    d0 = done_cnt_s;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!draw_s && n < 20) begin @(negedge clk); n++; end
    check("rst_reach_issue", draw_s, 1);
    rst_s = 1'b0;
    #1;
    check("rst_async_draw", draw_s, 0);
    check("rst_async_busy", busy_s, 0);
    check("rst_async_done", done_s, 0);
    @(negedge clk); @(negedge clk);
    rst_s = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_idle_after", {busy_s, draw_s}, 0);
    check("rst_no_done", done_cnt_s - d0, 0);

    // Stale drawer_active, then a start pulse while busy
    n0 = q_s.size(); d0 = done_cnt_s;
    force_s = 1'b1;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);                       // cycle 1
    start_s = 1'b0;
    bad = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (draw_s) bad = 1'b1;
      if (c == 6) force_s = 1'b0;
      @(negedge clk);
    end
    check("stale_no_early_draw", bad, 0);
    check("stale_draw_c8", draw_s, 1);
    repeat (3) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1'b0, 300, "stale");
    repeat (10) @(negedge clk);
    check("busy_start_ignored_count", q_s.size() - n0, 4);
    check("busy_start_one_done", done_cnt_s - d0, 1);
    check("busy_start_idle", busy_s, 0);

    // Skip-id map
    mem_s[0] = 8'h01; mem_s[1] = 8'hFF; mem_s[2] = 8'hFF; mem_s[3] = 8'h02;
    n0 = q_s.size(); d0 = done_cnt_s;
`ifdef TILE_SKIP_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1'b0, 300, "skip");
    @(negedge clk);
    check("skip_draw_count", q_s.size() - n0, exp_n);
    if (q_s.size() - n0 == exp_n) begin
      check("skip_first", q_s[n0], 24'h010000);
      check("skip_last", q_s[n0+exp_n-1], 24'h020808);
    end
    check("skip_done", done_cnt_s - d0, 1);

    // Default 20x15 map; entry 255 is 8'hFF
`ifdef TILE_SKIP_EN
    exp_n = 299;
`else
    exp_n = 300;
`endif
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 20000, "big");
    @(negedge clk);
    check("big_draw_count", q_b.size(), exp_n);
    if (q_b.size() == exp_n) begin
      check("big_first", q_b[0], 24'h000000);
      check("big_draw21", q_b[21], {8'h15, 8'd8, 8'd8});
      check("big_last", q_b[exp_n-1], {8'h2B, 8'd152, 8'd112});
    end
    check("big_last_addr", last_addr_b, 299);
    check("big_done", done_cnt_b, 1);
    check("big_busy_after", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
